serial_lsb_comparator: RTL and testbench

- Bit-serial magnitude comparator for two unsigned WIDTH-bit operands.
- Scans in the opposite direction to the combinational MSB-first slice chain: one bit per clock, LSB first.
- Each more significant bit overrides the verdict from the lower bits.
- Result uses the same 2-bit status encoding as the slice chain, so it is a drop-in result source for the eight-bit comparator datapath.

---
 rtl/serial_lsb_comparator.sv | 118 +++++++++++
 tb/tb_serial_lsb_comparator.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_lsb_comparator.sv
// Bit-serial unsigned magnitude comparator, LSB first.
// Each clock compares one bit pair; a difference at a more significant
// bit overwrites whatever verdict the lower bits produced, so after the
// MSB the working status holds the full-width result.
// Result encoding: 2'b10 A>B, 2'b01 A==B, 2'b00 A<B.
module serial_lsb_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [1:0]       z
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic [1:0]       z_q, z_d;

  logic load;
  logic bit_gt;
  logic bit_lt;

  // A new comparison is accepted in IDLE and in DONE (back-to-back), never in RUN.
  assign load   = start && (state_q != RUN);
  assign bit_gt = sa_q[0] & ~sb_q[0];
  assign bit_lt = ~sa_q[0] & sb_q[0];

  // State and datapath registers.
  // NOTE: every register here is a handful of flops, so all of them get the
  // async reset; sequential state is always written with <= so the whole
  // block samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b1;
      z_q     <= 2'b01;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      z_q     <= z_d;
    end
  end

  // Next-state logic: load, per-bit verdict update and shift, result capture.
  // NOTE: every next-state signal is given its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    z_d     = z_q;

    if (load) begin
      sa_d    = a;
      sb_d    = b;
      cnt_d   = '0;
      gt_d    = 1'b0;
      eq_d    = 1'b1;
      state_d = RUN;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        RUN: begin
          // Later (more significant) differences overwrite earlier ones.
          if (bit_gt) begin
            gt_d = 1'b1;
            eq_d = 1'b0;
          end else if (bit_lt) begin
            gt_d = 1'b0;
            eq_d = 1'b0;
          end
          sa_d  = {1'b0, sa_q[WIDTH-1:1]};
          sb_d  = {1'b0, sb_q[WIDTH-1:1]};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
            z_d     = {gt_d, eq_d};
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign z    = z_q;

endmodule

// File: tb/tb_serial_lsb_comparator.sv
// Testbench for serial_lsb_comparator: an 8-bit and a 2-bit instance.
// Stimulus pushes {expected z, expected done cycle} into per-instance
// queues; monitors pop and compare on every done pulse.
module tb_serial_lsb_comparator;

  typedef struct {
    logic [1:0] z;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       busy8, done8;
  logic [1:0] z8;
  logic       start2 = 1'b0;
  logic [1:0] a2 = '0;
  logic [1:0] b2 = '0;
  logic       busy2, done2;
  logic [1:0] z2;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_bad = 0;
  exp_t q8[$];
  exp_t q2[$];

  serial_lsb_comparator #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .z(z8)
  );

  serial_lsb_comparator #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .z(z2)
  );

  always #5 clk = ~clk;

  // Count rising edges; at a negedge, cyc equals the number of edges so far.
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        check("w8_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("w8_z", int'(z8), int'(e.z));
        check("w8_done_cycle", cyc, e.cyc);
        check("w8_busy_in_done", int'(busy8), 0);
      end
    end
  end

  // Monitor for the 2-bit instance.
  always @(negedge clk) begin
    if (rst_n && done2) begin
      if (q2.size() == 0) begin
        check("w2_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q2.pop_front();
        check("w2_z", int'(z2), int'(e.z));
        check("w2_done_cycle", cyc, e.cyc);
      end
    end
  end

  // Drive start at the current negedge; accepting edge is cyc+1.
  task automatic issue8_now(input logic [7:0] av, input logic [7:0] bv,
                            input logic [1:0] ez, input bit expect_done);
    exp_t e;
    start8 = 1'b1;
    a8 = av;
    b8 = bv;
    e.z = ez;
    e.cyc = cyc + 1 + 8;
    if (expect_done) q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic issue8(input logic [7:0] av, input logic [7:0] bv,
                        input logic [1:0] ez, input bit expect_done);
    @(negedge clk);
    issue8_now(av, bv, ez, expect_done);
  endtask

  task automatic issue2(input logic [1:0] av, input logic [1:0] bv,
                        input logic [1:0] ez);
    exp_t e;
    @(negedge clk);
    start2 = 1'b1;
    a2 = av;
    b2 = bv;
    e.z = ez;
    e.cyc = cyc + 1 + 2;
    q2.push_back(e);
    @(negedge clk);
    start2 = 1'b0;
  endtask

  // Returns at the negedge where done is high; bounded.
  task automatic wait_done(input bit narrow);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (narrow ? done2 : done8) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) check(narrow ? "w2_done_timeout" : "w8_done_timeout", 0, 1);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy8), 0);
    check("rst_done", int'(done8), 0);
    check("rst_z", int'(z8), 2'b01);
    rst_n = 1'b1;
    @(negedge clk);

    // Equal operands: busy for exactly 8 sampled cycles, then done.
    issue8(8'hA5, 8'hA5, 2'b01, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check("a5_busy_run", int'(busy8), 1);
      @(negedge clk);
    end
    check("a5_busy_after", int'(busy8), 0);
    check("a5_done", int'(done8), 1);
    @(negedge clk);
    check("a5_done_one_cycle", int'(done8), 0);

    // MSB overrides lower-bit verdicts; z holds through IDLE.
    issue8(8'h80, 8'h7F, 2'b10, 1'b1);
    wait_done(1'b0);
    repeat (3) @(negedge clk);
    check("z_hold_idle", int'(z8), 2'b10);

    // A<B, then back-to-back start in the DONE cycle.
    issue8(8'h01, 8'h02, 2'b00, 1'b1);
    wait_done(1'b0);
    issue8_now(8'hFF, 8'h00, 2'b10, 1'b1);
    check("b2b_busy", int'(busy8), 1);
    check("z_hold_run", int'(z8), 2'b00);
    wait_done(1'b0);
    @(negedge clk);

    // start held through RUN with operands changed mid-run.
    start8 = 1'b1;
    a8 = 8'h3C;
    b8 = 8'h3B;
    begin
      exp_t e;
      e.z = 2'b10;
      e.cyc = cyc + 1 + 8;
      q8.push_back(e);
    end
    @(negedge clk);
    a8 = 8'h00;
    b8 = 8'hFF;
    wait_done(1'b0);
    begin
      exp_t e;
      e.z = 2'b00;
      e.cyc = cyc + 1 + 8;
      q8.push_back(e);
    end
    @(negedge clk);
    start8 = 1'b0;
    check("held_restart_busy", int'(busy8), 1);
    wait_done(1'b0);
    @(negedge clk);

    // Reset in RUN cycle 4: immediate clear, no done afterwards.
    issue8(8'h10, 8'h20, 2'b00, 1'b0);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", int'(busy8), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy8), 0);
    check("mid_rst_done", int'(done8), 0);
    check("mid_rst_z", int'(z8), 2'b01);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_idle", int'(busy8), 0);

    // More boundary vectors.
    issue8(8'hFF, 8'hFF, 2'b01, 1'b1); wait_done(1'b0);
    issue8(8'h00, 8'h00, 2'b01, 1'b1); wait_done(1'b0);
    issue8(8'h7F, 8'h80, 2'b00, 1'b1); wait_done(1'b0);
    issue8(8'hFE, 8'hFF, 2'b00, 1'b1); wait_done(1'b0);
    issue8(8'h01, 8'h00, 2'b10, 1'b1); wait_done(1'b0);

    // WIDTH=2 exhaustive.
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        logic [1:0] ez;
        ez = (i > j) ? 2'b10 : ((i == j) ? 2'b01 : 2'b00);
        issue2(2'(i), 2'(j), ez);
        wait_done(1'b1);
      end
    end

    repeat (4) @(negedge clk);
    check("w8_queue_drained", q8.size(), 0);
    check("w2_queue_drained", q2.size(), 0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
